// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate types for the VGA path.
package vga_timing_pkg;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 33;
   localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int unsigned COORD_W = 10;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } vga_pos_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the sync generator to the renderer.
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   logic   Hsync;
   logic   Vsync;
   logic   displayON;
   coord_t Xpixel;
   coord_t Ypixel;
   logic   pixel_en;
   logic   frame_start;

   modport master (
      output Hsync, Vsync, displayON, Xpixel, Ypixel, pixel_en, frame_start
   );

   modport slave (
      input Hsync, Vsync, displayON, Xpixel, Ypixel, pixel_en, frame_start
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with sync/active decode.
// o_count and the decode flags describe the value the counter holds after
// the current edge, so a register loaded on an advance edge stays coherent.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned FP     = VGA_H_FP,
   parameter int unsigned SYNC   = VGA_H_SYNC,
   parameter int unsigned BP     = VGA_H_BP
) (
   input  logic   CLK,
   input  logic   reset_n,
   input  logic   i_adv,
   output coord_t o_count,
   output logic   o_wrap,
   output logic   o_in_sync,
   output logic   o_in_active
);

   localparam int unsigned Total     = ACTIVE + FP + SYNC + BP;
   localparam coord_t      Last      = coord_t'(Total - 1);
   localparam int unsigned SyncStart = ACTIVE + FP;
   localparam int unsigned SyncEnd   = ACTIVE + FP + SYNC;

   coord_t r_count;
   coord_t w_count_nxt;
   logic   w_at_last;

   // Next position: hold unless advancing, wrap at the last position.
   always_comb begin
      w_at_last   = (r_count == Last);
      w_count_nxt = r_count;
      if (i_adv) begin
         w_count_nxt = w_at_last ? '0 : r_count + coord_t'(1);
      end
   end

   // Reset parks on the last position so the first advance lands on 0.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= Last;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   // Compare in 32 bits so a 1024-wide axis cannot overflow the bounds.
   assign o_count     = w_count_nxt;
   assign o_wrap      = i_adv & w_at_last;
   assign o_in_sync   = (32'(w_count_nxt) >= SyncStart) && (32'(w_count_nxt) < SyncEnd);
   assign o_in_active = (32'(w_count_nxt) < ACTIVE);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel clock-enable divider, horizontal and
// vertical axis counters, and registered sync/active/coordinate outputs.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = vga_timing_pkg::VGA_H_ACTIVE,
   parameter int unsigned H_FP     = vga_timing_pkg::VGA_H_FP,
   parameter int unsigned H_SYNC   = vga_timing_pkg::VGA_H_SYNC,
   parameter int unsigned H_BP     = vga_timing_pkg::VGA_H_BP,
   parameter int unsigned V_ACTIVE = vga_timing_pkg::VGA_V_ACTIVE,
   parameter int unsigned V_FP     = vga_timing_pkg::VGA_V_FP,
   parameter int unsigned V_SYNC   = vga_timing_pkg::VGA_V_SYNC,
   parameter int unsigned V_BP     = vga_timing_pkg::VGA_V_BP,
   parameter int unsigned CLK_DIV  = 2,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic           CLK,
   input  logic           reset_n,
   vga_sync_gen_if.master vga
);

   localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

   logic [DivW-1:0] r_div;
   logic            w_tick;

   coord_t   w_h;
   coord_t   w_v;
   logic     w_h_wrap;
   logic     w_v_wrap;
   logic     w_h_sync;
   logic     w_v_sync;
   logic     w_h_act;
   logic     w_v_act;

   vga_pos_t r_pos;
   logic     r_hsync;
   logic     r_vsync;
   logic     r_display_on;
   logic     r_pixel_en;
   logic     r_frame_start;

   assign w_tick = (r_div == DivLast);

   // Pixel-rate clock enable: count CLK cycles within the current pixel.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_div <= '0;
      end else begin
         r_div <= w_tick ? '0 : r_div + DivW'(1);
      end
   end

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .CLK         (CLK),
      .reset_n     (reset_n),
      .i_adv       (w_tick),
      .o_count     (w_h),
      .o_wrap      (w_h_wrap),
      .o_in_sync   (w_h_sync),
      .o_in_active (w_h_act)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .CLK         (CLK),
      .reset_n     (reset_n),
      .i_adv       (w_h_wrap),
      .o_count     (w_v),
      .o_wrap      (w_v_wrap),
      .o_in_sync   (w_v_sync),
      .o_in_active (w_v_act)
   );

   // Output registers load the decode of the new position on each tick and
   // hold between ticks; a vertical wrap means the new position is (0,0).
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_pos         <= '0;
         r_hsync       <= ~SYNC_POL;
         r_vsync       <= ~SYNC_POL;
         r_display_on  <= 1'b0;
         r_pixel_en    <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_pixel_en    <= w_tick;
         r_frame_start <= w_v_wrap;
         if (w_tick) begin
            r_pos        <= '{x: w_h, y: w_v};
            r_hsync      <= w_h_sync ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= w_v_sync ? SYNC_POL : ~SYNC_POL;
            r_display_on <= w_h_act & w_v_act;
         end
      end
   end

   assign vga.Hsync       = r_hsync;
   assign vga.Vsync       = r_vsync;
   assign vga.displayON   = r_display_on;
   assign vga.Xpixel      = r_pos.x;
   assign vga.Ypixel      = r_pos.y;
   assign vga.pixel_en    = r_pixel_en;
   assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance (CLK_DIV=2, active-low
// sync) and a shrunken-raster instance (CLK_DIV=1, active-high sync) run side
// by side under randomized mid-frame resets. A pixel-index model predicts
// every pixel; a monitor compares the outputs every cycle.
module tb_vga_sync_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       de;
      logic       hs;
      logic       vs;
      logic       fs;
      logic       pe;
   } obs_t;

   logic CLK = 1'b0;
   logic reset_n;

   int checks = 0;
   int errors = 0;

   // Raster configuration of each instance: index 0 full size, 1 small.
   int cfg_ha  [2] = '{640, 16};
   int cfg_hf  [2] = '{16, 2};
   int cfg_hs  [2] = '{96, 3};
   int cfg_hb  [2] = '{48, 4};
   int cfg_va  [2] = '{480, 10};
   int cfg_vf  [2] = '{10, 2};
   int cfg_vs  [2] = '{2, 2};
   int cfg_vb  [2] = '{33, 3};
   int cfg_div [2] = '{2, 1};
   bit cfg_pol [2] = '{1'b0, 1'b1};

   int   cyc  [2];
   obs_t last [2];
   obs_t q_a [$];
   obs_t q_b [$];

   vga_sync_gen_if if_a ();
   vga_sync_gen_if if_b ();

   vga_sync_gen dut_a (
      .CLK     (CLK),
      .reset_n (reset_n),
      .vga     (if_a)
   );

   vga_sync_gen #(
      .H_ACTIVE (16),
      .H_FP     (2),
      .H_SYNC   (3),
      .H_BP     (4),
      .V_ACTIVE (10),
      .V_FP     (2),
      .V_SYNC   (2),
      .V_BP     (3),
      .CLK_DIV  (1),
      .SYNC_POL (1'b1)
   ) dut_b (
      .CLK     (CLK),
      .reset_n (reset_n),
      .vga     (if_b)
   );

   always #5 CLK = ~CLK;

   function automatic obs_t rst_obs(int j);
      obs_t o;
      o    = '0;
      o.hs = ~cfg_pol[j];
      o.vs = ~cfg_pol[j];
      return o;
   endfunction

   // Expected outputs for the k-th pixel shown since reset release.
   function automatic obs_t pix_obs(int j, int k);
      obs_t o;
      int ht, vt, x, y, hs0, vs0;
      ht  = cfg_ha[j] + cfg_hf[j] + cfg_hs[j] + cfg_hb[j];
      vt  = cfg_va[j] + cfg_vf[j] + cfg_vs[j] + cfg_vb[j];
      x   = k % ht;
      y   = (k / ht) % vt;
      hs0 = cfg_ha[j] + cfg_hf[j];
      vs0 = cfg_va[j] + cfg_vf[j];
      o.x  = 10'(x);
      o.y  = 10'(y);
      o.de = (x < cfg_ha[j]) && (y < cfg_va[j]);
      o.hs = ((x >= hs0) && (x < hs0 + cfg_hs[j])) ? cfg_pol[j] : ~cfg_pol[j];
      o.vs = ((y >= vs0) && (y < vs0 + cfg_vs[j])) ? cfg_pol[j] : ~cfg_pol[j];
      o.fs = (x == 0) && (y == 0);
      o.pe = 1'b1;
      return o;
   endfunction

   function automatic obs_t act_obs(int j);
      obs_t o;
      if (j == 0) begin
         o = {if_a.Xpixel, if_a.Ypixel, if_a.displayON, if_a.Hsync, if_a.Vsync,
              if_a.frame_start, if_a.pixel_en};
      end else begin
         o = {if_b.Xpixel, if_b.Ypixel, if_b.displayON, if_b.Hsync, if_b.Vsync,
              if_b.frame_start, if_b.pixel_en};
      end
      return o;
   endfunction

   task automatic q_push(input int j, input obs_t e);
      if (j == 0) q_a.push_back(e);
      else        q_b.push_back(e);
   endtask

   task automatic q_pop(input int j, output obs_t e);
      if (j == 0) e = q_a.pop_front();
      else        e = q_b.pop_front();
   endtask

   task automatic q_clear(input int j);
      if (j == 0) q_a.delete();
      else        q_b.delete();
   endtask

   function automatic int q_size(int j);
      return (j == 0) ? q_a.size() : q_b.size();
   endfunction

   task automatic compare(input string name, input int j, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b pe=%b exp x=%0d y=%0d de=%b hs=%b vs=%b fs=%b pe=%b",
                  name, j, $time, act.x, act.y, act.de, act.hs, act.vs, act.fs, act.pe,
                  exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.fs, exp.pe);
      end
   endtask

   // Reference model: every CLK_DIV-th edge after release shows the next pixel.
   initial begin
      forever begin
         @(posedge CLK);
         for (int j = 0; j < 2; j++) begin
            if (!reset_n) begin
               cyc[j] = 0;
               q_clear(j);
            end else begin
               cyc[j]++;
               if (cyc[j] % cfg_div[j] == 0) q_push(j, pix_obs(j, cyc[j] / cfg_div[j] - 1));
            end
         end
      end
   end

   // Monitor: a predicted pixel must appear now; otherwise outputs hold.
   initial begin
      forever begin
         @(negedge CLK);
         for (int j = 0; j < 2; j++) begin
            obs_t act, exp;
            act = act_obs(j);
            if (!reset_n) begin
               exp     = rst_obs(j);
               last[j] = exp;
               q_clear(j);
               compare("reset_state", j, act, exp);
            end else if (q_size(j) > 0) begin
               q_pop(j, exp);
               last[j]    = exp;
               last[j].pe = 1'b0;
               last[j].fs = 1'b0;
               compare("pixel", j, act, exp);
            end else begin
               exp = last[j];
               compare("hold", j, act, exp);
            end
         end
      end
   end

   initial begin
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (5) @(posedge CLK);
      #3 reset_n = 1'b1;
      repeat (4000) @(posedge CLK);
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(3000, 50)) @(posedge CLK);
         // Assert between edges; outputs must clear without waiting for CLK.
         #3 reset_n = 1'b0;
         #1;
         for (int j = 0; j < 2; j++) compare("async_reset", j, act_obs(j), rst_obs(j));
         repeat ($urandom_range(3, 1)) @(posedge CLK);
         #3 reset_n = 1'b1;
      end
      repeat (2000) @(posedge CLK);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
